// File: rtl/line_memory_ctrl.sv
// Main-memory model for the cache-to-memory bus: whole-line read/write bursts of
// 16-bit beats, a programmable access latency, and a RESPONSE for every request.
module line_memory_ctrl #(
    parameter int ADDR_W      = 14,
    parameter int LINE_BYTES  = 16,
    parameter int MEM_LATENCY = 100
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] m_addr,
    input  logic [1:0]        m_ctrl_in,
    input  logic [15:0]       m_data_in,
    output logic [1:0]        m_ctrl_out,
    output logic              m_ctrl_oe,
    output logic [15:0]       m_data_out,
    output logic              m_data_oe,
    output logic              busy
);
    localparam int BEATS  = LINE_BYTES * 8 / 16;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int CNT_W  = $clog2(MEM_LATENCY);

    localparam logic [1:0]        CMD_RESPONSE = 2'd1;
    localparam logic [1:0]        CMD_READ     = 2'd2;
    localparam logic [1:0]        CMD_WRITE    = 2'd3;
    localparam logic [CNT_W-1:0]  CNT_LOAD     = CNT_W'(MEM_LATENCY - 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT    = BEAT_W'(BEATS - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_BURST,
        WR_BURST,
        WR_WAIT,
        WR_ACK
    } state_t;

    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    logic [BEAT_W-1:0]       beat;
    logic [ADDR_W-1:0]       addr_q;
    logic [BEATS-1:0][15:0]  wbuf;
    logic [BEATS-1:0][15:0]  commit_line;
    logic [BEATS-1:0][15:0]  mem [0:(1 << ADDR_W) - 1];

    assign busy = (state != IDLE);

    // Buffer contents including the word arriving this cycle; on the last beat
    // this is exactly the line that gets committed.
    always_comb begin
        commit_line       = wbuf;
        commit_line[beat] = m_data_in;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            beat       <= '0;
            m_ctrl_oe  <= 1'b0;
            m_ctrl_out <= 2'd0;
            m_data_oe  <= 1'b0;
            m_data_out <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (m_ctrl_in == CMD_READ) begin
                        cnt   <= CNT_LOAD;
                        state <= RD_WAIT;
                    end else if (m_ctrl_in == CMD_WRITE) begin
                        beat  <= BEAT_W'(1);
                        state <= WR_BURST;
                    end
                end
                RD_WAIT: begin
                    if (cnt == '0) begin
                        beat       <= '0;
                        m_ctrl_oe  <= 1'b1;
                        m_ctrl_out <= CMD_RESPONSE;
                        m_data_oe  <= 1'b1;
                        m_data_out <= mem[addr_q][0];
                        state      <= RD_BURST;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                RD_BURST: begin
                    // beat holds the index currently on the bus
                    if (beat == LAST_BEAT) begin
                        m_ctrl_oe  <= 1'b0;
                        m_ctrl_out <= 2'd0;
                        m_data_oe  <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        beat       <= beat + BEAT_W'(1);
                        m_data_out <= mem[addr_q][beat + BEAT_W'(1)];
                    end
                end
                WR_BURST: begin
                    if (beat == LAST_BEAT) begin
                        cnt   <= CNT_LOAD;
                        state <= WR_WAIT;
                    end else begin
                        beat <= beat + BEAT_W'(1);
                    end
                end
                WR_WAIT: begin
                    if (cnt == '0) begin
                        m_ctrl_oe  <= 1'b1;
                        m_ctrl_out <= CMD_RESPONSE;
                        state      <= WR_ACK;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                WR_ACK: begin
                    m_ctrl_oe  <= 1'b0;
                    m_ctrl_out <= 2'd0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Datapath: address latch, write buffer and the line array (never reset).
    always_ff @(posedge clk) begin
        if (state == IDLE && m_ctrl_in[1])
            addr_q <= m_addr;
        if (state == IDLE && m_ctrl_in == CMD_WRITE)
            wbuf[0] <= m_data_in;
        if (state == WR_BURST)
            wbuf <= commit_line;
        if (!reset && state == WR_BURST && beat == LAST_BEAT)
            mem[addr_q] <= commit_line;
    end
endmodule
